// File: rtl/gpu_mem_pkg.sv
// Shared types for the memory request controller:
// request entry layout and controller FSM states.
package gpu_mem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic              error;
  } mem_req_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    ERR
  } state_e;

endpackage

// File: rtl/req_fifo.sv
// Show-ahead request FIFO with occupancy count.
// Pointers wrap naturally because DEPTH is a power of two.
module req_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  T                       din,
  output T                       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    cnt;
  logic           do_push;
  logic           do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      cnt <= cnt + 1'b1;
      else if (do_pop && !do_push) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// Buffers translated requests and issues them one at a time to memory;
// out-of-bounds requests are answered locally with an error response.
module mem_req_ctrl
  import gpu_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [ADDR_WIDTH-1:0] i_physical_addr,
  input  logic                  i_error,
  input  logic                  i_we,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_ready,
  output logic                  o_mem_req_valid,
  input  logic                  i_mem_req_ready,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_we,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                  i_mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_resp_valid,
  output logic [DATA_WIDTH-1:0] o_resp_data,
  output logic                  o_resp_error,
  output logic                  o_busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  error;
  } entry_t;

  entry_t          din;
  entry_t          head;
  logic            full;
  logic            empty;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;

  state_e          state;
  state_e          state_d;
  logic            mem_valid_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic            mem_we_d;
  logic [DATA_WIDTH-1:0] mem_wdata_d;
  logic            resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_data_d;
  logic            resp_error_d;

  assign din  = '{addr: i_physical_addr, we: i_we,
                  wdata: i_wdata, error: i_error};
  assign push = i_valid && !full;

  assign o_ready = !full;
  assign o_busy  = (count != '0) || (state != IDLE);

  req_fifo #(
    .DEPTH(DEPTH),
    .T    (entry_t)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .din  (din),
    .dout (head),
    .full (full),
    .empty(empty),
    .count(count)
  );

  always_comb begin
    state_d      = state;
    pop          = 1'b0;
    mem_valid_d  = o_mem_req_valid;
    mem_addr_d   = o_mem_addr;
    mem_we_d     = o_mem_we;
    mem_wdata_d  = o_mem_wdata;
    resp_valid_d = 1'b0;
    resp_data_d  = '0;
    resp_error_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          if (head.error) begin
            // error response is registered on entry to ERR
            pop          = 1'b1;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
            state_d      = ERR;
          end else begin
            mem_valid_d = 1'b1;
            mem_addr_d  = head.addr;
            mem_we_d    = head.we;
            mem_wdata_d = head.wdata;
            state_d     = REQ;
          end
        end
      end
      REQ: begin
        if (i_mem_req_ready) begin
          pop         = 1'b1;
          mem_valid_d = 1'b0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (i_mem_resp_valid) begin
          resp_valid_d = 1'b1;
          resp_data_d  = o_mem_we ? '0 : i_mem_rdata;
          state_d      = IDLE;
        end
      end
      ERR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      o_mem_req_valid <= 1'b0;
      o_mem_addr      <= '0;
      o_mem_we        <= 1'b0;
      o_mem_wdata     <= '0;
      o_resp_valid    <= 1'b0;
      o_resp_data     <= '0;
      o_resp_error    <= 1'b0;
    end else begin
      state           <= state_d;
      o_mem_req_valid <= mem_valid_d;
      o_mem_addr      <= mem_addr_d;
      o_mem_we        <= mem_we_d;
      o_mem_wdata     <= mem_wdata_d;
      o_resp_valid    <= resp_valid_d;
      o_resp_data     <= resp_data_d;
      o_resp_error    <= resp_error_d;
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed self-checking bench for mem_req_ctrl.
// Cycle N is sampled 1ns after the Nth rising edge.
module tb_mem_req_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic [31:0] i_physical_addr;
  logic        i_error;
  logic        i_we;
  logic [31:0] i_wdata;
  logic        o_ready;
  logic        o_mem_req_valid;
  logic        i_mem_req_ready;
  logic [31:0] o_mem_addr;
  logic        o_mem_we;
  logic [31:0] o_mem_wdata;
  logic        i_mem_resp_valid;
  logic [31:0] i_mem_rdata;
  logic        o_resp_valid;
  logic [31:0] o_resp_data;
  logic        o_resp_error;
  logic        o_busy;

  int checks   = 0;
  int failures = 0;

  mem_req_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_valid         (i_valid),
    .i_physical_addr (i_physical_addr),
    .i_error         (i_error),
    .i_we            (i_we),
    .i_wdata         (i_wdata),
    .o_ready         (o_ready),
    .o_mem_req_valid (o_mem_req_valid),
    .i_mem_req_ready (i_mem_req_ready),
    .o_mem_addr      (o_mem_addr),
    .o_mem_we        (o_mem_we),
    .o_mem_wdata     (o_mem_wdata),
    .i_mem_resp_valid(i_mem_resp_valid),
    .i_mem_rdata     (i_mem_rdata),
    .o_resp_valid    (o_resp_valid),
    .o_resp_data     (o_resp_data),
    .o_resp_error    (o_resp_error),
    .o_busy          (o_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [31:0] a, input logic w,
                         input logic e, input logic [31:0] d);
    i_valid         = 1'b1;
    i_physical_addr = a;
    i_we            = w;
    i_error         = e;
    i_wdata         = d;
  endtask

  // one cycle of a memory model answering one cycle after acceptance
  task automatic step_mem(output bit pushed, output bit hs,
                          output logic [31:0] hs_addr);
    pushed  = i_valid && o_ready;
    hs      = o_mem_req_valid && i_mem_req_ready;
    hs_addr = o_mem_addr;
    tick();
    i_mem_resp_valid = hs;
    i_mem_rdata      = hs ? rd_of(hs_addr) : 32'h0;
  endtask

  task automatic idle_inputs;
    i_valid          = 1'b0;
    i_physical_addr  = '0;
    i_error          = 1'b0;
    i_we             = 1'b0;
    i_wdata          = '0;
    i_mem_req_ready  = 1'b0;
    i_mem_resp_valid = 1'b0;
    i_mem_rdata      = '0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (o_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b want=1", o_ready);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b want=0", o_busy);
    end
    checks++;
    if ({o_mem_req_valid, o_mem_addr, o_mem_we, o_mem_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_mem got v=%b a=%h we=%b d=%h want 0",
               o_mem_req_valid, o_mem_addr, o_mem_we, o_mem_wdata);
    end
    checks++;
    if ({o_resp_valid, o_resp_data, o_resp_error} !== '0) begin
      failures++;
      $display("FAIL reset_resp got v=%b d=%h e=%b want 0",
               o_resp_valid, o_resp_data, o_resp_error);
    end
  endtask

  task automatic test_single_read;
    i_mem_req_ready = 1'b1;
    set_req(32'h100, 1'b0, 1'b0, 32'h0);
    tick();
    i_valid = 1'b0;
    checks++;
    if (o_mem_req_valid !== 1'b0 || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL read_c1 got v=%b busy=%b want v=0 busy=1",
               o_mem_req_valid, o_busy);
    end
    tick();
    checks++;
    if (o_mem_req_valid !== 1'b1 || o_mem_addr !== 32'h100 ||
        o_mem_we !== 1'b0) begin
      failures++;
      $display("FAIL read_c2 got v=%b a=%h we=%b want v=1 a=100 we=0",
               o_mem_req_valid, o_mem_addr, o_mem_we);
    end
    tick();
    i_mem_resp_valid = 1'b1;
    i_mem_rdata      = 32'hDEAD_BEEF;
    checks++;
    if (o_mem_req_valid !== 1'b0 || o_resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL read_c3 got v=%b rv=%b want 0 0",
               o_mem_req_valid, o_resp_valid);
    end
    tick();
    i_mem_resp_valid = 1'b0;
    i_mem_rdata      = '0;
    checks++;
    if (o_resp_valid !== 1'b1 || o_resp_data !== 32'hDEAD_BEEF ||
        o_resp_error !== 1'b0) begin
      failures++;
      $display("FAIL read_c4 got rv=%b d=%h e=%b want 1 deadbeef 0",
               o_resp_valid, o_resp_data, o_resp_error);
    end
    tick();
    checks++;
    if (o_resp_valid !== 1'b0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL read_c5 got rv=%b busy=%b want 0 0",
               o_resp_valid, o_busy);
    end
    i_mem_req_ready = 1'b0;
  endtask

  task automatic test_error;
    bit saw_mem = 1'b0;
    i_mem_req_ready = 1'b1;
    set_req(32'h2000, 1'b0, 1'b1, 32'h0);
    tick();
    i_valid = 1'b0;
    i_error = 1'b0;
    saw_mem |= o_mem_req_valid;
    checks++;
    if (o_resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL err_c1 got rv=%b want 0", o_resp_valid);
    end
    tick();
    saw_mem |= o_mem_req_valid;
    checks++;
    if (o_resp_valid !== 1'b1 || o_resp_error !== 1'b1 ||
        o_resp_data !== 32'h0) begin
      failures++;
      $display("FAIL err_c2 got rv=%b e=%b d=%h want 1 1 0",
               o_resp_valid, o_resp_error, o_resp_data);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      saw_mem |= o_mem_req_valid;
    end
    checks++;
    if (saw_mem !== 1'b0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL err_nomem got memvalid_seen=%b busy=%b want 0 0",
               saw_mem, o_busy);
    end
    i_mem_req_ready = 1'b0;
  endtask

  task automatic test_fill;
    int idx = 0;
    int nhs = 0;
    int nresp = 0;
    bit p, h;
    logic [31:0] ha;
    i_mem_req_ready = 1'b0;
    set_req(32'h40, 1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 20 && idx < 4; c++) begin
      step_mem(p, h, ha);
      if (p) idx++;
      set_req(32'h40 + 32'(idx) * 4, 1'b0, 1'b0, 32'h0);
    end
    checks++;
    if (idx !== 4 || o_ready !== 1'b0) begin
      failures++;
      $display("FAIL fill_full got pushed=%0d ready=%b want 4 0",
               idx, o_ready);
    end
    for (int c = 0; c < 3; c++) begin
      step_mem(p, h, ha);
      if (p) idx++;
    end
    checks++;
    if (idx !== 4 || o_ready !== 1'b0) begin
      failures++;
      $display("FAIL fill_stall got pushed=%0d ready=%b want 4 0",
               idx, o_ready);
    end
    i_mem_req_ready = 1'b1;
    for (int c = 0; c < 80 && nresp < 5; c++) begin
      step_mem(p, h, ha);
      if (p) begin
        idx++;
        i_valid = 1'b0;
      end
      if (h) begin
        checks++;
        if (nhs > 4 || ha !== 32'h40 + 32'(nhs) * 4) begin
          failures++;
          $display("FAIL fill_order[%0d] got a=%h want %h",
                   nhs, ha, 32'h40 + 32'(nhs) * 4);
        end
        nhs++;
      end
      if (o_resp_valid) begin
        checks++;
        if (o_resp_data !== rd_of(32'h40 + 32'(nresp) * 4) ||
            o_resp_error !== 1'b0) begin
          failures++;
          $display("FAIL fill_resp[%0d] got d=%h e=%b want %h 0",
                   nresp, o_resp_data, o_resp_error,
                   rd_of(32'h40 + 32'(nresp) * 4));
        end
        nresp++;
      end
    end
    checks++;
    if (nresp !== 5 || nhs !== 5) begin
      failures++;
      $display("FAIL fill_count got resp=%0d hs=%0d want 5 5",
               nresp, nhs);
    end
    i_valid          = 1'b0;
    i_mem_req_ready  = 1'b0;
    i_mem_resp_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure;
    logic [31:0] a0, d0;
    logic        w0;
    int nhs = 0;
    int nresp = 0;
    bit p, h;
    logic [31:0] ha;
    i_mem_req_ready = 1'b0;
    set_req(32'h300, 1'b1, 1'b0, 32'h1234_5678);
    tick();
    i_valid = 1'b0;
    tick();
    a0 = o_mem_addr;
    w0 = o_mem_we;
    d0 = o_mem_wdata;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (o_mem_req_valid !== 1'b1 || o_mem_addr !== 32'h300 ||
          o_mem_we !== 1'b1 || o_mem_wdata !== 32'h1234_5678 ||
          o_mem_addr !== a0 || o_mem_we !== w0 || o_mem_wdata !== d0) begin
        failures++;
        $display("FAIL bp_hold[%0d] got v=%b a=%h we=%b d=%h want 1 300 1 12345678",
                 c, o_mem_req_valid, o_mem_addr, o_mem_we, o_mem_wdata);
      end
      if (c < 2) tick();
    end
    i_mem_req_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step_mem(p, h, ha);
      if (h) nhs++;
      if (o_resp_valid) begin
        nresp++;
        checks++;
        if (o_resp_data !== 32'h0 || o_resp_error !== 1'b0) begin
          failures++;
          $display("FAIL bp_resp got d=%h e=%b want 0 0",
                   o_resp_data, o_resp_error);
        end
      end
    end
    checks++;
    if (nhs !== 1 || nresp !== 1 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_once got hs=%0d resp=%0d busy=%b want 1 1 0",
               nhs, nresp, o_busy);
    end
    i_mem_req_ready  = 1'b0;
    i_mem_resp_valid = 1'b0;
  endtask

  task automatic test_mixed;
    logic [31:0] ra [3];
    logic        rw [3];
    logic        re [3];
    logic [31:0] ed [3];
    logic        ee [3];
    logic [31:0] eh [2];
    int idx = 0;
    int nhs = 0;
    int nresp = 0;
    bit p, h, spur;
    logic [31:0] ha;
    ra = '{32'h10, 32'h2000, 32'h20};
    rw = '{1'b1, 1'b0, 1'b0};
    re = '{1'b0, 1'b1, 1'b0};
    ed = '{32'h0, 32'h0, 32'h20 ^ 32'hC0DE_0000};
    ee = '{1'b0, 1'b1, 1'b0};
    eh = '{32'h10, 32'h20};
    i_mem_req_ready = 1'b1;
    set_req(ra[0], rw[0], re[0], 32'hAAAA_5555);
    for (int c = 0; c < 60 && nresp < 3; c++) begin
      step_mem(p, h, ha);
      if (p) idx++;
      if (idx < 3) set_req(ra[idx], rw[idx], re[idx], 32'hAAAA_5555);
      else i_valid = 1'b0;
      if (h) begin
        checks++;
        if (nhs > 1 || ha !== eh[nhs[0]]) begin
          failures++;
          $display("FAIL mix_hs[%0d] got a=%h", nhs, ha);
        end
        nhs++;
      end
      if (o_resp_valid) begin
        checks++;
        if (o_resp_data !== ed[nresp] || o_resp_error !== ee[nresp]) begin
          failures++;
          $display("FAIL mix_resp[%0d] got d=%h e=%b want %h %b",
                   nresp, o_resp_data, o_resp_error, ed[nresp], ee[nresp]);
        end
        nresp++;
      end
    end
    checks++;
    if (nresp !== 3 || nhs !== 2) begin
      failures++;
      $display("FAIL mix_count got resp=%0d hs=%0d want 3 2", nresp, nhs);
    end
    i_valid          = 1'b0;
    i_mem_req_ready  = 1'b0;
    tick();
    tick();
    i_mem_resp_valid = 1'b1;
    i_mem_rdata      = 32'h5A5A_5A5A;
    tick();
    i_mem_resp_valid = 1'b0;
    spur = o_resp_valid;
    tick();
    spur |= o_resp_valid;
    checks++;
    if (spur !== 1'b0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL spurious_resp got rv=%b busy=%b want 0 0", spur, o_busy);
    end
  endtask

  task automatic test_reset_in_wait;
    bit saw = 1'b0;
    i_mem_req_ready = 1'b1;
    set_req(32'h500, 1'b0, 1'b0, 32'h0);
    tick();
    set_req(32'h504, 1'b0, 1'b0, 32'h0);
    tick();
    i_valid = 1'b0;
    checks++;
    if (o_mem_req_valid !== 1'b1 || o_mem_addr !== 32'h500) begin
      failures++;
      $display("FAIL rstw_req got v=%b a=%h want 1 500",
               o_mem_req_valid, o_mem_addr);
    end
    tick();
    rst_n            = 1'b0;
    i_mem_resp_valid = 1'b1;
    i_mem_rdata      = 32'h1111_2222;
    tick();
    checks++;
    if (o_resp_valid !== 1'b0 || o_busy !== 1'b0 || o_ready !== 1'b1 ||
        o_mem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstw_state got rv=%b busy=%b rdy=%b mv=%b want 0 0 1 0",
               o_resp_valid, o_busy, o_ready, o_mem_req_valid);
    end
    rst_n            = 1'b1;
    i_mem_resp_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      saw |= o_mem_req_valid | o_resp_valid | o_busy;
    end
    checks++;
    if (saw !== 1'b0) begin
      failures++;
      $display("FAIL rstw_empty got activity=%b want 0", saw);
    end
    i_mem_req_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_error();
    test_fill();
    test_backpressure();
    test_mixed();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_req_ctrl.md
# mem_req_ctrl

Memory request controller sitting directly downstream of the base/bound address translator. Buffers translated requests in a small FIFO and issues them one at a time to the memory port over a valid/ready handshake. Returns one response pulse per accepted request. Requests flagged as out-of-bounds never reach memory and get an immediate error response.

## Interface
Parameters:
- ADDR_WIDTH, 32, physical address width
- DATA_WIDTH, 32, read/write data width
- DEPTH, 4, request FIFO entries; power of two, ≥2

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous and active-low (sampled on rising clk)
- i_valid  in  1  request present, independent of i_error
- i_physical_addr  in  ADDR_WIDTH  translated address
- i_error  in  1  translator bound violation for this request
- i_we  in  1  1 = write, 0 = read
- i_wdata  in  DATA_WIDTH  write data
- o_ready  out  1  FIFO can accept; equals !full
- o_mem_req_valid  out  1  memory request valid
- i_mem_req_ready  in  1  memory accepts request
- o_mem_addr  out  ADDR_WIDTH  memory address
- o_mem_we  out  1  memory write enable
- o_mem_wdata  out  DATA_WIDTH  memory write data
- i_mem_resp_valid  in  1  memory response/ack, one cycle
- i_mem_rdata  in  DATA_WIDTH  read data, valid with i_mem_resp_valid
- o_resp_valid  out  1  response pulse, one cycle, no backpressure
- o_resp_data  out  DATA_WIDTH  read data; 0 for writes and errors
- o_resp_error  out  1  request was out of bounds
- o_busy  out  1  FIFO non-empty or FSM not in IDLE

## Operation
- Enqueue on i_valid && o_ready. The entry is {addr, we, wdata, error}. i_valid while !o_ready is dropped; upstream must hold it.
- FSM states: IDLE, REQ, WAIT, ERR.
- IDLE with FIFO non-empty:
  - head.error = 1: pop, go to ERR.
  - otherwise: load head into registered o_mem_* outputs, go to REQ.
- REQ:
  - o_mem_req_valid = 1; addr/we/wdata held stable until handshake.
  - On i_mem_req_ready: pop, go to WAIT.
- WAIT:
  - On i_mem_resp_valid: register o_resp_valid = 1 and o_resp_error = 0.
  - o_resp_data = i_mem_rdata for reads, 0 for writes.
  - Go to IDLE.
- ERR: o_resp_valid = 1, o_resp_error = 1, o_resp_data = 0; go to IDLE.
- One outstanding memory transaction at most. Responses return in request order.
- i_mem_resp_valid outside WAIT is ignored. i_mem_req_ready outside REQ is ignored.
- FIFO count width is $clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Enqueue and pop in the same cycle: count unchanged, both pointers advance.
- Full: o_ready = 0. No bypass and no same-cycle enqueue-on-pop when full.

## Timing
- Reset values: o_ready = 1. All other outputs = 0: o_mem_req_valid, o_mem_addr, o_mem_we, o_mem_wdata, o_resp_valid, o_resp_data, o_resp_error, o_busy. FSM = IDLE, FIFO empty.
- Reset mid-transaction discards the FIFO and any outstanding request. The memory side is reset together.
- o_ready and o_busy are combinational from count/state. All o_mem_* and o_resp_* outputs are registered.
- Best-case read, enqueue in cycle 0:
  - cycle 1: IDLE sees the entry.
  - cycle 2: o_mem_req_valid high; if i_mem_req_ready is high, WAIT follows in cycle 3.
  - cycle 3: i_mem_resp_valid.
  - cycle 4: o_resp_valid.
- Error request, enqueue in cycle 0: o_resp_valid with o_resp_error = 1 in cycle 2.
- Back-to-back: IDLE costs one cycle between transactions. The next o_mem_req_valid comes ≥1 cycle after o_resp_valid.

## Structure
- Package gpu_mem_pkg:
  - mem_req_t struct {addr, we, wdata, error}, parameterised by width localparams
  - state enum {IDLE, REQ, WAIT, ERR}
- Sub-module req_fifo:
  - parameterised DEPTH and entry type
  - ports: push, pop, din, dout (head, show-ahead), full, empty, count
  - synchronous active-low reset

## Test plan
- Reset: after rst_n low for 2 cycles, then high → o_ready = 1, o_busy = 0, all other outputs 0. Assert rst_n low during WAIT → next cycle state IDLE, FIFO empty, no o_resp_valid.
- Single read to 0x100, mem_req_ready tied 1, response 0xDEADBEEF one cycle after acceptance → o_mem_addr = 0x100, o_mem_we = 0 in cycle 2; o_resp_valid with o_resp_data = 0xDEADBEEF in cycle 4.
- Error request (i_error = 1, addr 0x2000) → no o_mem_req_valid ever; o_resp_valid = 1, o_resp_error = 1, o_resp_data = 0 in cycle 2.
- Fill: 5 back-to-back requests with mem_req_ready = 0 → o_ready drops after entry 4 is accepted and the 5th stalls. Releasing ready drains all 5 in order, with addresses matching enqueue order.
- Backpressure: mem_req_ready low for 3 cycles while o_mem_req_valid is high → o_mem_addr/we/wdata stable all 3 cycles; exactly one pop.
- Mixed sequence write 0x10 / error / read 0x20 → three responses in order: (data 0, err 0), (data 0, err 1), (read data, err 0). Spurious i_mem_resp_valid while IDLE produces no response.
